xadc_drp_sequencer: RTL and testbench
=====================================

// Module: xadc_drp_sequencer
// PURPOSE
//  Drives the XADC DRP port on behalf of the board logic. On each conversion event (eoc) it reads
//  a list of NUM_CH status registers back-to-back, one DRP transaction at a time, and stores the
//  12-bit results in a per-channel bank. Sits between xadc_wiz_0 and display/LED consumers.
//  Consumers can take the streamed samples or read the bank. The DRP port is never written.
// PARAMETERS
//  NUM_CH    4                        channels per sweep, 1..4
//  CH_ADDRS  28'h1F_1E_17_16 ({ch3,..,ch0}, 7b each)  DRP address per channel index
//  TIMEOUT   255                      max cycles from den to drdy before abort, 1..255
// PORTS
//  CLK100MHZ    in   1   system clock, DRP dclk
//  reset        in   1   asynchronous, active-high
//  eoc_in       in   1   XADC eoc_out; each cycle it is high is one trigger
//  den_out      out  1   DRP enable, single-cycle pulse
//  dwe_out      out  1   DRP write enable, tied 0
//  daddr_out    out  7   DRP address, held from the den cycle until drdy or abort
//  do_in        in   16  DRP read data
//  drdy_in      in   1   DRP data ready
//  smp_valid    out  1   one-cycle pulse, new sample on smp_data/smp_ch
//  smp_data     out  12  do_in[15:4] of the completed read
//  smp_ch       out  2   channel index of smp_data
//  rd_sel       in   2   bank read select
//  rd_data      out  12  bank[rd_sel], registered, 1-cycle latency
//  sweep_done   out  1   one-cycle pulse after the last channel of a sweep
//  overrun      out  1   sticky; set when a trigger is lost
//  timeout_err  out  1   sticky; set when a DRP read is aborted
//  err_clr      in   1   clears overrun and timeout_err
// BEHAVIOUR
//  Reset: FSM=IDLE, idx=0, pending=0, bank all 0; every output is 0.
//  FSM states:
//   IDLE: on eoc_in or pending -> REQ, idx=0, pending cleared.
//   REQ: den_out=1 for exactly this cycle, daddr_out=CH_ADDRS[7*idx+:7] -> WAIT, tmo_cnt=0.
//   WAIT: drdy_in -> capture do_in[15:4] into bank[idx], go to NEXT.
//     tmo_cnt reaches TIMEOUT without drdy -> set timeout_err, bank unchanged, no smp_valid, go to NEXT.
//   NEXT: idx==NUM_CH-1 -> sweep_done=1, go to IDLE; otherwise idx++ and go to REQ.
//  Timing:
//   eoc -> den latency: 1 cycle, since den is asserted in REQ on the cycle after the trigger.
//   On capture, smp_valid/smp_data/smp_ch are registered and appear the cycle after drdy.
//  Only one DRP transaction is outstanding at a time. den_out is never asserted outside REQ.
//  drdy_in outside WAIT is ignored.
//  Trigger arriving outside IDLE: if pending=0, set pending; if pending=1, set overrun.
//   A pending trigger starts the next sweep straight from IDLE, with no extra idle cycle.
//  eoc_in together with the IDLE->REQ transition: that trigger is the one being consumed.
//  err_clr has priority below a same-cycle set, so the flag stays 1 in that case.
//  Bank write and a same-cycle rd_sel read of the same entry: rd_data returns the old value.
//  rd_sel >= NUM_CH: rd_data=0.
//  reset asserted mid-transaction: the read is abandoned immediately and den_out drops at once.
//   A late drdy after reset is ignored because the FSM is in IDLE.
// CONFIGURATION
//  XADC_AVG_EN defined:
//   Each channel keeps a 14-bit accumulator and a 2-bit count.
//   On every 4th capture, the bank and smp_data take acc[13:2] (truncating mean of 4 samples);
//    acc and count are then cleared.
//   smp_valid pulses only on those averaged updates. sweep_done is unchanged.
//   Timed-out reads do not add to the accumulator or advance the count. reset clears all accumulators.
//  XADC_AVG_EN undefined: every capture goes straight to the bank and to smp_data. No accumulator logic.
// TESTING
//  1. Single sweep:
//     Stimulus: one eoc pulse. DRP model returns 16'hABC0 for addr 16h and 16'h1230 for 17h,
//      drdy 3 cycles after den.
//     Expect den at addrs 16h,17h,1Eh,1Fh in order; smp_data=ABC then 123.
//     Expect sweep_done once; bank[0]=ABC.
//  2. Timeout:
//     Stimulus: model never answers addr 17h; TIMEOUT=8.
//     Expect timeout_err=1 9 cycles after that den; bank[1] unchanged; the sweep still finishes.
//  3. Overrun:
//     Stimulus: 3 eoc pulses during one sweep.
//     Expect exactly 2 sweeps; overrun=1. After err_clr, overrun=0.
//  4. Reset mid-transaction:
//     Stimulus: assert reset during WAIT; model drdy arrives after reset is released.
//     Expect den_out=0 during reset; all outputs 0; no smp_valid; no bank write.
//  5. Bank read:
//     Stimulus: after test 1, rd_sel=0, then rd_sel=3 on the next cycle.
//     Expect rd_data=ABC one cycle after rd_sel=0, then bank[3] on the following cycle.
//  6. XADC_AVG_EN:
//     Stimulus: channel 0 returns samples 100,101,102,103.
//     Expect a single smp_valid for ch0, with data=101 (406>>2), after the 4th sweep.

Source files
------------

// File: rtl/xadc_drp_sequencer.sv
// XADC DRP read sequencer: each eoc triggers a read sweep of NUM_CH status registers into a bank.
// Build option XADC_AVG_EN: publish the truncating mean of every 4 captures per channel.
module xadc_drp_sequencer #(
  parameter int unsigned NUM_CH   = 4,
  parameter logic [27:0] CH_ADDRS = {7'h1F, 7'h1E, 7'h17, 7'h16},
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        eoc_in,
  output logic        den_out,
  output logic        dwe_out,
  output logic [6:0]  daddr_out,
  input  logic [15:0] do_in,
  input  logic        drdy_in,
  output logic        smp_valid,
  output logic [11:0] smp_data,
  output logic [1:0]  smp_ch,
  input  logic [1:0]  rd_sel,
  output logic [11:0] rd_data,
  output logic        sweep_done,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        err_clr
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, NEXT} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_CH - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [1:0]  idx;
  logic        pending;
  logic [7:0]  tmo_cnt;
  logic [11:0] bank [4];
  logic [4:0]  addr_lsb;
  logic [6:0]  ch_addr;
  logic        cap_p0, abort_p0, upd_p0;
  logic [11:0] smp_p0, upd_data_p0;
  logic        unused_do;

  assign dwe_out   = 1'b0;
  assign unused_do = ^do_in[3:0];
  assign smp_p0    = do_in[15:4];
  assign addr_lsb  = 5'(idx) * 5'd7;
  assign ch_addr   = CH_ADDRS[addr_lsb +: 7];

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    den_out    = 1'b0;
    daddr_out  = '0;
    sweep_done = 1'b0;
    cap_p0     = 1'b0;
    abort_p0   = 1'b0;
    case (state)
      IDLE: if (eoc_in || pending) state_n = REQ;
      REQ: begin
        den_out   = 1'b1;
        daddr_out = ch_addr;
        state_n   = WAIT;
      end
      WAIT: begin
        daddr_out = ch_addr;
        // drdy wins over the timeout on the last allowed cycle
        if (drdy_in) begin
          cap_p0  = 1'b1;
          state_n = NEXT;
        end else if (tmo_cnt == TMO_LAST) begin
          abort_p0 = 1'b1;
          state_n  = NEXT;
        end
      end
      NEXT: begin
        if (idx == LAST_IDX) begin
          sweep_done = 1'b1;
          state_n    = IDLE;
        end else begin
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef XADC_AVG_EN
  logic [13:0] acc [4];
  logic [1:0]  acc_cnt [4];
  logic [13:0] acc_sum;

  function automatic logic [11:0] mean4(input logic [13:0] sum);
    return sum[13:2];
  endfunction

  assign acc_sum     = acc[idx] + {2'b00, smp_p0};
  assign upd_p0      = cap_p0 && (acc_cnt[idx] == 2'd3);
  assign upd_data_p0 = mean4(acc_sum);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        acc[i]     <= '0;
        acc_cnt[i] <= '0;
      end
    end else if (cap_p0) begin
      if (upd_p0) begin
        acc[idx]     <= '0;
        acc_cnt[idx] <= '0;
      end else begin
        acc[idx]     <= acc_sum;
        acc_cnt[idx] <= acc_cnt[idx] + 2'd1;
      end
    end
  end
`else
  assign upd_p0      = cap_p0;
  assign upd_data_p0 = smp_p0;
`endif

  // ---- p0 -> p1: registered sample stream, bank, flags ----
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      pending     <= 1'b0;
      tmo_cnt     <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      smp_valid   <= 1'b0;
      smp_data    <= '0;
      smp_ch      <= '0;
      rd_data     <= '0;
      for (int i = 0; i < 4; i++) bank[i] <= '0;
    end else begin
      if (state == IDLE)                         idx <= '0;
      else if (state == NEXT && idx != LAST_IDX) idx <= idx + 2'd1;

      tmo_cnt <= (state == WAIT) ? tmo_cnt + 8'd1 : '0;

      // a trigger arriving while one is already queued is the lost one
      if (state == IDLE) pending <= 1'b0;
      else if (eoc_in)   pending <= 1'b1;

      if (eoc_in && pending) overrun <= 1'b1;
      else if (err_clr)      overrun <= 1'b0;

      if (abort_p0)     timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      smp_valid <= upd_p0;
      if (upd_p0) begin
        smp_data  <= upd_data_p0;
        smp_ch    <= idx;
        bank[idx] <= upd_data_p0;
      end

      rd_data <= (32'(rd_sel) < NUM_CH) ? bank[rd_sel] : '0;
    end
  end
endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Bench for xadc_drp_sequencer: plays the DRP slave with random data/latency and predicts stream and bank.
module tb_xadc_drp_sequencer;
  localparam int NUM_CH = 4;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        reset, eoc_in, den_out, dwe_out, drdy_in, smp_valid;
  logic        sweep_done, overrun, timeout_err, err_clr;
  logic [6:0]  daddr_out;
  logic [15:0] do_in;
  logic [11:0] smp_data, rd_data;
  logic [1:0]  smp_ch, rd_sel;

  xadc_drp_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT(TMO)) dut (
    .CLK100MHZ(clk), .reset(reset), .eoc_in(eoc_in), .den_out(den_out), .dwe_out(dwe_out),
    .daddr_out(daddr_out), .do_in(do_in), .drdy_in(drdy_in), .smp_valid(smp_valid),
    .smp_data(smp_data), .smp_ch(smp_ch), .rd_sel(rd_sel), .rd_data(rd_data),
    .sweep_done(sweep_done), .overrun(overrun), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_mism = 0;
  int          n_smp = 0, n_done = 0, n_den = 0;
  int          exp_smp = 0, exp_done = 0, exp_den = 0;
  logic [11:0] exp_bank [4];
  logic        exp_tmo, exp_ovr;
  int          hist [4][$];
  logic [15:0] sw_dat [4];
  int          sw_lat [4];
  logic [63:0] eoc_sched;
  int          sw_cyc;
  bit          clr_on_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] addr_of(input int ch);
    case (ch)
      0:       return 7'h16;
      1:       return 7'h17;
      2:       return 7'h1E;
      default: return 7'h1F;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_bank[i] = '0;
      hist[i].delete();
    end
    exp_tmo = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // Averaging build publishes mean of each group of 4 samples; otherwise every sample.
  task automatic model_capture(input int ch, input logic [11:0] s, output bit emit, output logic [11:0] val);
`ifdef XADC_AVG_EN
    int sum;
    hist[ch].push_back(int'(s));
    emit = 1'b0;
    val  = '0;
    if (hist[ch].size() == 4) begin
      sum = 0;
      foreach (hist[ch][j]) sum += hist[ch][j];
      val  = 12'(sum / 4);
      emit = 1'b1;
      hist[ch].delete();
    end
`else
    emit = 1'b1;
    val  = s;
`endif
    if (emit) begin
      exp_bank[ch] = val;
      exp_smp++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sw_cyc++;
    if (smp_valid)  n_smp++;
    if (sweep_done) n_done++;
    if (den_out)    n_den++;
    eoc_in  = (sw_cyc < 64) ? eoc_sched[sw_cyc] : 1'b0;
    drdy_in = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic setup_random(input bit allow_tmo, input int min_lat);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sw_dat[ch] = 16'($urandom);
      sw_lat[ch] = int'($urandom_range(TMO, min_lat));
      if (allow_tmo && $urandom_range(5, 0) == 0) sw_lat[ch] = 0;
    end
  endtask

  // Acts as DRP slave for one sweep; sw_lat==0 means the read is never answered.
  task automatic sweep(input bit self_trig);
    logic [11:0] old;
    logic [11:0] val;
    bit          emit;
    int          k;
    sw_cyc = 0;
    if (self_trig) eoc_in = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (!den_out && k < 20);
      chk("den_seen", den_out, 1);
      exp_den++;
      if (ch == 0) chk("first_den_cycle", sw_cyc, self_trig ? 1 : 2);
      chk("daddr", daddr_out, addr_of(ch));
      chk("dwe", dwe_out, 0);
      if (sw_lat[ch] > 0) begin
        for (int i = 0; i < sw_lat[ch]; i++) tick();
        do_in   = sw_dat[ch];
        drdy_in = 1'b1;
        rd_sel  = 2'(ch);
        old     = exp_bank[ch];
        tick();
        chk("bank_rd_old", rd_data, old);
        model_capture(ch, sw_dat[ch][15:4], emit, val);
        chk("smp_valid", smp_valid, emit);
        if (emit) begin
          chk("smp_data", smp_data, val);
          chk("smp_ch", smp_ch, ch);
        end
      end else begin
        for (int i = 0; i < TMO; i++) tick();
        chk("tmo_before", timeout_err, exp_tmo);
        if (clr_on_abort) err_clr = 1'b1;
        tick();
        exp_tmo = 1'b1;
        chk("tmo_set", timeout_err, 1);
        chk("no_smp_on_abort", smp_valid, 0);
      end
      chk("sweep_done", sweep_done, ch == NUM_CH - 1);
    end
    exp_done++;
    chk("tmo_flag", timeout_err, exp_tmo);
    chk("ovr_flag", overrun, exp_ovr);
  endtask

  task automatic read_bank(input int sel);
    rd_sel = 2'(sel);
    tick();
    chk("bank_read", rd_data, exp_bank[sel]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; eoc_in = 1'b0; drdy_in = 1'b0; do_in = '0; rd_sel = '0; err_clr = 1'b0;
    eoc_sched = '0; sw_cyc = 0; clr_on_abort = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_den", den_out, 0);
    chk("rst_daddr", daddr_out, 0);
    chk("rst_smp_valid", smp_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_flags", {overrun, timeout_err, sweep_done}, 0);
    reset = 1'b0;
    idle(2);

    // single sweep with known data, drdy 3 cycles after den
    sw_dat[0] = 16'hABC0; sw_dat[1] = 16'h1230;
    sw_dat[2] = 16'($urandom); sw_dat[3] = 16'($urandom);
    for (int ch = 0; ch < NUM_CH; ch++) sw_lat[ch] = 3;
    sweep(1);
    idle(1);
    rd_sel = 2'd0;
    tick();
    chk("bank0_read", rd_data, exp_bank[0]);
`ifndef XADC_AVG_EN
    chk("bank0_abc", rd_data, 12'hABC);
`endif
    rd_sel = 2'd3;
    tick();
    chk("bank3_read", rd_data, exp_bank[3]);

    // timeout on channel 1 with err_clr on the same cycle as the set
    setup_random(1'b0, 1);
    sw_lat[1] = 0;
    clr_on_abort = 1'b1;
    sweep(1);
    clr_on_abort = 1'b0;
    idle(1);
    read_bank(1);
    err_clr = 1'b1;
    tick();
    exp_tmo = 1'b0;
    chk("tmo_clr", timeout_err, 0);

    // three triggers in one sweep: one pending, one lost
    setup_random(1'b0, 2);
    eoc_sched[3] = 1'b1;
    eoc_sched[6] = 1'b1;
    exp_ovr = 1'b1;
    sweep(1);
    eoc_sched = '0;
    setup_random(1'b0, 1);
    sweep(0);
    idle(15);
    chk("den_count_ovr", n_den, exp_den);
    chk("done_count_ovr", n_done, exp_done);
    err_clr = 1'b1;
    tick();
    exp_ovr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // reset while den is high drops it immediately
    idle(1);
    eoc_in = 1'b1;
    tick();
    chk("req_den", den_out, 1);
    exp_den++;
    reset = 1'b1;
    #1;
    chk("rst_req_den_drop", den_out, 0);
    #1 reset = 1'b0;
    model_reset();
    idle(2);

    // reset during WAIT, drdy arrives after release
    eoc_in = 1'b1;
    tick();
    chk("wait_den", den_out, 1);
    exp_den++;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rstw_den", den_out, 0);
    chk("rstw_daddr", daddr_out, 0);
    chk("rstw_smp", {smp_valid, smp_ch, smp_data}, 0);
    chk("rstw_rd_data", rd_data, 0);
    chk("rstw_flags", {overrun, timeout_err, sweep_done}, 0);
    #1 reset = 1'b0;
    tick();
    do_in   = 16'hFFF0;
    drdy_in = 1'b1;
    tick();
    chk("late_drdy_ignored", smp_valid, 0);
    for (int i = 0; i < NUM_CH; i++) read_bank(i);

    // channel 0 returns 100..103 over four sweeps
    for (int s = 0; s < 4; s++) begin
      setup_random(1'b0, 1);
      sw_dat[0] = 16'((100 + s) << 4);
      sweep(1);
      idle(1);
    end
    rd_sel = 2'd0;
    tick();
`ifdef XADC_AVG_EN
    chk("avg_ch0", rd_data, 12'd101);
`else
    chk("last_ch0", rd_data, 12'd103);
`endif

    // random sweeps with random latency and occasional timeouts
    for (int r = 0; r < 15; r++) begin
      setup_random(1'b1, 1);
      sweep(1);
      idle(int'($urandom_range(2, 1)));
    end
    for (int i = 0; i < NUM_CH; i++) read_bank(i);
    err_clr = 1'b1;
    tick();
    exp_tmo = 1'b0;
    chk("final_tmo_clr", timeout_err, 0);
    idle(5);
    chk("smp_count", n_smp, exp_smp);
    chk("done_count", n_done, exp_done);
    chk("den_count", n_den, exp_den);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end
endmodule
